// File: rtl/ifetch_pkg.sv
// Shared processor definitions: fetch address defaults and the fetch FSM state set.
package ifetch_pkg;

  // Byte address of the first instruction fetched after reset.
  localparam logic [31:0] RESET_PC  = 32'h0040_0000;
  // Base of the 2 KiB instruction ROM window (must be 2 KiB aligned).
  localparam logic [31:0] TEXT_BASE = 32'h0040_0000;

  // Fetch FSM: HALT and ERR are terminal until reset.
  typedef enum logic [1:0] {
    StRun  = 2'd0,
    StHalt = 2'd1,
    StErr  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ifetch.sv
// Instruction fetch stage: PC register, next-PC selection, window/alignment
// checking and a RUN/HALT/ERR FSM. Issues one registered instruction per
// cycle with one-cycle latency from the combinational ROM.
module ifetch #(
  parameter logic [31:0] RESET_PC  = ifetch_pkg::RESET_PC,
  parameter logic [31:0] TEXT_BASE = ifetch_pkg::TEXT_BASE
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [8:0]  rom_adrs,
  input  logic [31:0] rom_dout,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        valid_out,
  output logic        fetch_err
);

  import ifetch_pkg::*;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pcout_q, pcout_d;
  logic         valid_q, valid_d;
  logic         err_q, err_d;

  logic [31:0]  pc_next;
  logic         take_redirect;
  logic         misaligned;
  logic         out_of_window;

  // The ROM is word addressed inside the 2 KiB window.
  assign rom_adrs = pc_q[10:2];

  // Candidate next PC; under stall the redirect is ignored and the PC holds.
  always_comb begin
    take_redirect = redirect & ~stall;
    if (stall) begin
      pc_next = pc_q;
    end else if (redirect) begin
      pc_next = redirect_pc;
    end else begin
      pc_next = pc_q + 32'd4;
    end
    misaligned    = take_redirect & (redirect_pc[1:0] != 2'b00);
    out_of_window = (pc_next[31:11] != TEXT_BASE[31:11]);
  end

  // Next-state and output register updates, priority halt > error > stall > redirect > sequential.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pcout_d = pcout_q;
    valid_d = valid_q;
    err_d   = err_q;

    unique case (state_q)
      StRun: begin
        if (halt) begin
          state_d = StHalt;
          valid_d = 1'b0;
        end else if (misaligned || out_of_window) begin
          state_d = StErr;
          err_d   = 1'b1;
          valid_d = 1'b0;
        end else if (!stall) begin
          // Word fetched this cycle issues even when redirecting (delay slot).
          instr_d = rom_dout;
          pcout_d = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_next;
        end
      end
      StHalt: begin
        valid_d = 1'b0;
      end
      StErr: begin
        valid_d = 1'b0;
        err_d   = 1'b1;
      end
      default: begin
        state_d = StErr;
        err_d   = 1'b1;
        valid_d = 1'b0;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      pcout_q <= 32'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcout_q <= pcout_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign instr_out = instr_q;
  assign pc_out    = pcout_q;
  assign valid_out = valid_q;
  assign fetch_err = err_q;

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: behavioural fetch model plus directed and random stimulus.
module tb_ifetch;

  localparam logic [31:0] TB_RESET_PC  = 32'h0040_0000;
  localparam logic [31:0] TB_TEXT_BASE = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [8:0]  rom_adrs;
  logic [31:0] rom_dout;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        valid_out;
  logic        fetch_err;

  logic [31:0] rom [512];

  int checks   = 0;
  int failures = 0;

  // Model state: mode 0 = fetching, 1 = halted, 2 = errored.
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pcout;
  logic        m_valid;
  logic        m_err;
  logic        cmp_en = 1'b0;

  ifetch #(
    .RESET_PC  (TB_RESET_PC),
    .TEXT_BASE (TB_TEXT_BASE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rom_adrs    (rom_adrs),
    .rom_dout    (rom_dout),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .instr_out   (instr_out),
    .pc_out      (pc_out),
    .valid_out   (valid_out),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  assign rom_dout = rom[rom_adrs];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One rising edge of the model, from the rules of the fetch stage.
  task automatic model_edge();
    logic [31:0] target;
    logic        bad;
    if (!rst_n) begin
      m_mode  = 0;
      m_pc    = TB_RESET_PC;
      m_instr = 0;
      m_pcout = 0;
      m_valid = 0;
      m_err   = 0;
      cmp_en  = 1'b1;
    end else if (m_mode == 0) begin
      if (halt) begin
        m_mode  = 1;
        m_valid = 0;
      end else begin
        if (stall)         target = m_pc;
        else if (redirect) target = redirect_pc;
        else               target = m_pc + 32'd4;
        bad = (target - TB_TEXT_BASE) >= 32'd2048;
        if (!stall && redirect && (redirect_pc % 4 != 0)) bad = 1'b1;
        if (bad) begin
          m_mode  = 2;
          m_err   = 1;
          m_valid = 0;
        end else if (!stall) begin
          m_instr = rom[(m_pc - TB_TEXT_BASE) / 4];
          m_pcout = m_pc;
          m_valid = 1;
          m_pc    = target;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    rst_n = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0; halt = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("rom_adrs", {23'd0, rom_adrs}, {23'd0, m_pc[10:2]});
      check("valid_out", {31'd0, valid_out}, {31'd0, m_valid});
      check("fetch_err", {31'd0, fetch_err}, {31'd0, m_err});
      check("pc_out", pc_out, m_pcout);
      check("instr_out", instr_out, m_instr);
    end
  end

  initial begin
    int n;
    for (int i = 0; i < 512; i++) rom[i] = $urandom;
    idle_inputs();

    // Reset values.
    rst_n = 1'b0;
    tick();
    tick();
    check("rst_pc_out", pc_out, 32'd0);
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_err", {31'd0, fetch_err}, 32'd0);
    check("rst_adrs", {23'd0, rom_adrs}, 32'd0);
    rst_n = 1'b1;

    // Free run after reset.
    tick();
    check("run0_pc", pc_out, 32'h0040_0000);
    check("run0_instr", instr_out, rom[0]);
    check("run0_valid", {31'd0, valid_out}, 32'd1);
    tick();
    check("run1_pc", pc_out, 32'h0040_0004);
    tick();
    check("run2_pc", pc_out, 32'h0040_0008);
    tick();
    check("run3_pc", pc_out, 32'h0040_000C);

    // Delay-slot redirect while fetching 0x00400058.
    do_reset();
    redirect = 1'b1; redirect_pc = 32'h0040_0050;
    tick();
    redirect = 1'b0;
    n = 0;
    while (m_pc != 32'h0040_0058 && n < 50) begin tick(); n++; end
    check("reach_58", {31'd0, (n < 50)}, 32'd1);
    redirect = 1'b1; redirect_pc = 32'h0040_0034;
    tick();
    redirect = 1'b0;
    check("dslot_pc", pc_out, 32'h0040_0058);
    check("redir_adrs", {23'd0, rom_adrs}, 32'h0000_000D);
    tick();
    check("target_pc", pc_out, 32'h0040_0034);
    check("target_instr", instr_out, rom[13]);

    // Stall for three cycles at pc_out 0x00400010, redirect pulsed during it.
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    check("pre_stall_pc", pc_out, 32'h0040_0010);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      redirect = (i == 1); redirect_pc = 32'h0040_0100;
      tick();
      check("stall_pc", pc_out, 32'h0040_0010);
      check("stall_valid", {31'd0, valid_out}, 32'd1);
    end
    stall = 1'b0; redirect = 1'b0;
    tick();
    check("resume_pc", pc_out, 32'h0040_0014);

    // Misaligned redirect is sticky until reset.
    do_reset();
    tick();
    tick();
    redirect = 1'b1; redirect_pc = 32'h0040_0036;
    tick();
    redirect = 1'b0;
    check("mis_err", {31'd0, fetch_err}, 32'd1);
    check("mis_valid", {31'd0, valid_out}, 32'd0);
    for (int i = 0; i < 3; i++) tick();
    check("mis_sticky", {31'd0, fetch_err}, 32'd1);
    rst_n = 1'b0;
    tick();
    check("clr_err", {31'd0, fetch_err}, 32'd0);
    check("clr_pc", pc_out, 32'd0);
    check("clr_instr", instr_out, 32'd0);
    check("clr_adrs", {23'd0, rom_adrs}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("first_pc", pc_out, 32'h0040_0000);
    check("first_valid", {31'd0, valid_out}, 32'd1);

    // Sequential wrap past the top of the window.
    do_reset();
    redirect = 1'b1; redirect_pc = 32'h0040_07FC;
    tick();
    redirect = 1'b0;
    check("wrap_adrs", {23'd0, rom_adrs}, 32'h0000_01FF);
    tick();
    check("wrap_err", {31'd0, fetch_err}, 32'd1);
    check("wrap_valid", {31'd0, valid_out}, 32'd0);

    // Halt beats stall and redirect.
    do_reset();
    tick();
    tick();
    halt = 1'b1; stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0040_0200;
    tick();
    idle_inputs();
    check("halt_valid", {31'd0, valid_out}, 32'd0);
    check("halt_adrs", {23'd0, rom_adrs}, 32'd2);
    for (int i = 0; i < 3; i++) tick();
    check("halt_frozen", {23'd0, rom_adrs}, 32'd2);
    check("halt_err", {31'd0, fetch_err}, 32'd0);

    // Random episodes.
    for (int ep = 0; ep < 10; ep++) begin
      do_reset();
      for (int c = 0; c < 80; c++) begin
        int k;
        rst_n    = ($urandom_range(0, 199) != 0);
        halt     = ($urandom_range(0, 149) == 0);
        stall    = ($urandom_range(0, 99) < 25);
        redirect = ($urandom_range(0, 99) < 15);
        k = $urandom_range(0, 99);
        if (k < 94)      redirect_pc = TB_TEXT_BASE + ($urandom_range(0, 511) * 4);
        else if (k < 97) redirect_pc = TB_TEXT_BASE + ($urandom_range(0, 511) * 4)
                                       + $urandom_range(1, 3);
        else             redirect_pc = $urandom;
        tick();
      end
    end

    idle_inputs();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
